// File: rtl/pwm_carrier_pkg.sv
// Shared types for the PWM carrier stage.
//   carrier_mode_t : sawtooth (up-count) or triangle (up/down) carrier shape
//   carrier_dir_t  : current counting direction of the triangle carrier
package pwm_carrier_pkg;

    typedef enum logic {
        CARRIER_SAWTOOTH = 1'b0,
        CARRIER_TRIANGLE = 1'b1
    } carrier_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } carrier_dir_t;

endpackage

// File: rtl/pwm_carrier_counter_compare.sv
// One PWM compare channel.
// Holds the channel's active compare value (shadow-loaded on i_load) and
// registers the raw PWM bit so that it lines up with the carrier counter.
// Ports:
//   clockIn      : system clock
//   reset        : synchronous, active-low reset
//   i_load       : load event, copy i_compare_in into the active register
//   i_force_low  : carrier stopped, force the PWM bit low
//   i_compare_in : shadow compare value for this channel
//   i_next_count : carrier value that becomes current on this edge
//   o_pwm        : registered PWM bit, high while count < active compare
module pwm_compare_channel
    import pwm_carrier_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clockIn,
    input  logic                     reset,
    input  logic                     i_load,
    input  logic                     i_force_low,
    input  logic [COUNTER_WIDTH-1:0] i_compare_in,
    input  logic [COUNTER_WIDTH-1:0] i_next_count,
    output logic                     o_pwm
);

    logic [COUNTER_WIDTH-1:0] r_compare_act;
    logic                     r_pwm;
    logic [COUNTER_WIDTH-1:0] w_compare_eff;

    // On a load edge the new compare already governs the count that starts
    // the new period, so compare against the incoming value directly.
    assign w_compare_eff = i_load ? i_compare_in : r_compare_act;

    always_ff @(posedge clockIn) begin
        if (!reset) begin
            r_compare_act <= '0;
            r_pwm         <= 1'b0;
        end else begin
            if (i_load) begin
                r_compare_act <= i_compare_in;
            end
            r_pwm <= i_force_low ? 1'b0 : (i_next_count < w_compare_eff);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_carrier_counter.sv
// PWM carrier counter.
// Advances a sawtooth or triangle carrier by one per timebase tick, compares
// it against per-channel compare values and emits a period-start pulse.
// Period, compare and mode are shadow-buffered and only take effect at the
// period boundary (or continuously while the carrier is disabled).
// Ports:
//   clockIn      : system clock
//   reset        : synchronous, active-low reset
//   enable       : run enable; low holds the carrier at 0
//   timebase     : single-cycle advance tick
//   counter_mode : 0 sawtooth, 1 triangle (shadow)
//   period_in    : carrier peak value (shadow)
//   compare_in   : per-channel compare, channel i at [i*W +: W] (shadow)
//   counter_out  : current carrier value
//   pwm_out      : raw PWM, bit i high while counter < compare i
//   period_start : one-clock pulse when the carrier returns to 0
module pwm_carrier_counter
    import pwm_carrier_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter int N_CHANNELS    = 3
) (
    input  logic                                clockIn,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                timebase,
    input  logic                                counter_mode,
    input  logic [COUNTER_WIDTH-1:0]            period_in,
    input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] compare_in,
    output logic [COUNTER_WIDTH-1:0]            counter_out,
    output logic [N_CHANNELS-1:0]               pwm_out,
    output logic                                period_start
);

    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] r_period_act;
    carrier_mode_t            r_mode_act;
    carrier_dir_t             r_dir;
    logic                     r_period_start;

    logic [COUNTER_WIDTH-1:0] w_count_next;
    carrier_dir_t             w_dir_next;
    logic                     w_load;
    logic                     w_period_start_next;
    logic [COUNTER_WIDTH-1:0] w_count_inc;
    logic [COUNTER_WIDTH-1:0] w_count_dec;

    assign w_count_inc = r_count + 1'b1;
    assign w_count_dec = r_count - 1'b1;

    always_comb begin
        w_count_next        = r_count;
        w_dir_next          = r_dir;
        w_load              = 1'b0;
        w_period_start_next = 1'b0;

        if (!enable) begin
            // Stopped: park at 0 and keep tracking the shadow inputs so a
            // restart begins with whatever is currently programmed.
            w_count_next = '0;
            w_dir_next   = DIR_UP;
            w_load       = 1'b1;
        end else if (timebase) begin
            if (r_mode_act == CARRIER_SAWTOOTH) begin
                // >= rather than == so an out-of-range count still wraps.
                if (r_count >= r_period_act) begin
                    w_count_next        = '0;
                    w_load              = 1'b1;
                    w_period_start_next = 1'b1;
                end else begin
                    w_count_next = w_count_inc;
                end
            end else begin
                if (r_period_act == '0) begin
                    w_count_next        = '0;
                    w_load              = 1'b1;
                    w_period_start_next = 1'b1;
                end else if (r_dir == DIR_UP) begin
                    if (r_count >= r_period_act) begin
                        // Safety turn-around if the count is already at/above peak.
                        w_count_next = w_count_dec;
                        w_dir_next   = DIR_DOWN;
                    end else begin
                        w_count_next = w_count_inc;
                        if (w_count_inc >= r_period_act) begin
                            w_dir_next = DIR_DOWN;
                        end
                    end
                end else begin
                    // <= 1 also catches a stray 0 while counting down.
                    if (r_count <= COUNTER_WIDTH'(1)) begin
                        w_count_next        = '0;
                        w_load              = 1'b1;
                        w_period_start_next = 1'b1;
                    end else begin
                        w_count_next = w_count_dec;
                    end
                end
            end
        end

        // Every new period starts counting up, whatever the new mode is.
        if (w_load) begin
            w_dir_next = DIR_UP;
        end
    end

    always_ff @(posedge clockIn) begin
        if (!reset) begin
            r_count        <= '0;
            r_period_act   <= '0;
            r_mode_act     <= CARRIER_SAWTOOTH;
            r_dir          <= DIR_UP;
            r_period_start <= 1'b0;
        end else begin
            r_count        <= w_count_next;
            r_dir          <= w_dir_next;
            r_period_start <= w_period_start_next;
            if (w_load) begin
                r_period_act <= period_in;
                r_mode_act   <= carrier_mode_t'(counter_mode);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CHANNELS; gi++) begin : g_channel
            pwm_compare_channel #(
                .COUNTER_WIDTH(COUNTER_WIDTH)
            ) u_channel (
                .clockIn     (clockIn),
                .reset       (reset),
                .i_load      (w_load),
                .i_force_low (!enable),
                .i_compare_in(compare_in[gi*COUNTER_WIDTH +: COUNTER_WIDTH]),
                .i_next_count(w_count_next),
                .o_pwm       (pwm_out[gi])
            );
        end
    endgenerate

    assign counter_out  = r_count;
    assign period_start = r_period_start;

endmodule

// File: doc/pwm_carrier_counter.md
Name: pwm_carrier_counter

Overview:
PWM carrier stage directly downstream of the timebase generator. It consumes the single-cycle timebase tick and advances a sawtooth or triangle carrier counter by one per tick. The counter is compared against N per-channel compare values to produce raw PWM outputs and a period-start sync pulse. Period, compare and mode updates are double-buffered and applied only at the period boundary, so no glitched or truncated pulses reach the downstream dead-time/gating logic.

Parameters:
COUNTER_WIDTH, 16, width of carrier counter, period and compare values
N_CHANNELS, 3, number of compare/PWM output channels

Ports:
clockIn  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset
enable  input  1  run enable; low = counter stopped and held at 0
timebase  input  1  single-cycle tick from the timebase generator; counter advances only when high
counter_mode  input  1  0 = up-count sawtooth, 1 = up/down triangle
period_in  input  COUNTER_WIDTH  carrier peak value, shadow-buffered
compare_in  input  N_CHANNELS*COUNTER_WIDTH  per-channel compare, channel i at bits [i*W +: W], shadow-buffered
counter_out  output  COUNTER_WIDTH  current carrier value
pwm_out  output  N_CHANNELS  raw PWM, bit i high while counter < active compare i
period_start  output  1  one-clock pulse when the carrier returns to 0

Behaviour:
- Reset (reset==0, sync): counter_out=0, direction=up, pwm_out=0, period_start=0, active period/compare/mode=0.
- Active registers: period_act, compare_act[i], mode_act. Load event copies the *_in inputs into the active registers in the same clock.
- enable==0: counter held 0, direction up, pwm_out=0, period_start=0. Active registers load every clock, so a restart uses current inputs.
- enable==1 and timebase==0: all state holds.
- Sawtooth (mode_act=0), on tick: if counter==period_act, counter<=0, period_start<=1 and load event. Otherwise counter<=counter+1. Period is period_act+1 ticks.
- Triangle (mode_act=1), on tick:
  - Up: counter+1; on reaching period_act, direction flips to down.
  - Down: counter-1; on reaching 0, direction flips to up, period_start<=1 and load event.
  - Period is 2*period_act ticks.
- period_act==0 in either mode: counter stays 0, period_start pulses on every tick, and a load event occurs every tick.
- Counter above period_act: cannot occur, because period loads only when counter==0. Implementation must still treat counter>=period_act as wrap (saw) or turn-around (triangle) as a safety measure.
- Mode change mid-period: takes effect only at the next load event. The direction register is forced to up at a load.
- pwm_out[i] is registered, computed as (next counter value < compare_act in effect for that value), so pwm_out aligns with counter_out (both updated on the same edge).
  - compare==0 gives constant low.
  - compare>period_act gives constant high.
  - Comparison is unsigned.
- period_start is high for exactly one clock, coincident with counter_out becoming 0. It is otherwise 0, including the first tick after enable rises.
- enable falling mid-period: stop immediately on the next clock, with no period completion.
- reset low mid-operation overrides enable and timebase.
- Arithmetic is unsigned COUNTER_WIDTH. Counter never wraps through all-ones except when period_act=2^W-1 in sawtooth, where the natural wrap coincides with the load.

Decomposition:
- Package pwm_carrier_pkg: typedef enum logic {CARRIER_SAWTOOTH=0, CARRIER_TRIANGLE=1} carrier_mode_t; typedef enum logic {DIR_UP, DIR_DOWN} carrier_dir_t.
- Sub-module pwm_compare_channel, instantiated N_CHANNELS times via generate. It holds compare_act for its channel, takes load and next_count, and registers the pwm bit.
- The counter, direction and period logic stay in the top module.

Test Plan:
- Sawtooth: period 4, compare {2,0,5}, tick every clock -> counter 0,1,2,3,4,0…; pwm[0] high 2 of 5 ticks, pwm[1] always 0, pwm[2] always 1; period_start every 5th tick.
- Triangle: period 4, compare[0]=2, tick every 2nd clock -> counter 0,1,2,3,4,3,2,1,0 repeating every 8 ticks (16 clocks); pwm[0] high at counts 0,1 (up) and 1 (down) = 3 of 8 ticks; one period_start per 8 ticks.
- Shadow update: sawtooth period 9, change period_in to 3 and compare to 1 at count 5 -> counter continues to 9, wraps, then cycles 0..3 with pwm[0] high only at count 0.
- Mode switch mid-period: set counter_mode 1 while sawtooth is at count 2 of period 6 -> sawtooth completes to 6→0, then triangle 0..6..0.
- Stop/restart: drop enable at count 3 -> next clock counter=0, pwm=0, no period_start; raise enable with period 2 -> first ticks 1,2,0 with period_start at the 0.
- Reset mid-run and period 0: reset low for 1 clock at count 7 -> all outputs 0 next clock; then period_in=0 with ticks -> counter stays 0, period_start pulses each tick.
